pacman_mouth_anim_ctrl: RTL and testbench

//   Sequences the Pac-Man mouth animation across three sprite frames: closed, half-open, open.

---
 rtl/pacman_mouth_anim_ctrl.sv | 147 ++++++++++++++
 tb/tb_pacman_mouth_anim_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pacman_mouth_anim_ctrl.sv
// pacman_mouth_anim_ctrl
//   Steps the Pac-Man mouth through closed -> half-open -> open -> half-open -> closed
//   on vertical-blank pulses, then picks the matching sprite ROM index and palette
//   colour for each pixel, flags transparent pixels (index 0) and registers the result.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   frame_start  1-cycle pulse at start of vertical blank
//   moving       1 = animate, 0 = freeze the mouth where it is
//   pix_valid    pixel lookup valid this cycle
//   idx_closed   sprite index from the closed-frame ROM
//   idx_half     sprite index from the half-open ROM
//   idx_open     sprite index from the open ROM
//   rgb_closed   closed palette colour {R,G,B}
//   rgb_half     half-open palette colour
//   rgb_open     open palette colour
//   frame_sel    active frame: 0 closed, 1 half, 2 open
//   out_valid    registered pixel valid
//   out_opaque   registered: valid and selected index != 0
//   out_rgb      registered colour, 12'h000 when not opaque

module pacman_mouth_anim_ctrl #(
  parameter int TICKS_PER_STEP = 4,
  parameter int IDX_W          = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             moving,
  input  logic             pix_valid,
  input  logic [IDX_W-1:0] idx_closed,
  input  logic [IDX_W-1:0] idx_half,
  input  logic [IDX_W-1:0] idx_open,
  input  logic [11:0]      rgb_closed,
  input  logic [11:0]      rgb_half,
  input  logic [11:0]      rgb_open,
  output logic [1:0]       frame_sel,
  output logic             out_valid,
  output logic             out_opaque,
  output logic [11:0]      out_rgb
);

  typedef enum logic [1:0] {
    CLOSED  = 2'd0,
    OPENING = 2'd1,
    OPEN    = 2'd2,
    CLOSING = 2'd3
  } state_t;

  localparam logic [7:0] LAST_TICK = 8'(TICKS_PER_STEP - 1);

  state_t     state, next_state;
  logic [7:0] tick_cnt, next_tick_cnt;
  logic [1:0] next_frame_sel;

  logic [IDX_W-1:0] sel_idx;
  logic [11:0]      sel_rgb;
  logic             opaque_next;
  logic [11:0]      rgb_next;

  // Animation state, tick counter and displayed frame. frame_sel is only ever
  // loaded alongside the state so the visible frame cannot change mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CLOSED;
      tick_cnt  <= '0;
      frame_sel <= 2'd0;
    end else begin
      state    <= next_state;
      tick_cnt <= next_tick_cnt;
      if (frame_start) begin
        frame_sel <= next_frame_sel;
      end
    end
  end

  // Step rule: nothing moves outside frame_start; a frozen mouth keeps its
  // partial count so the cadence resumes where it left off.
  always_comb begin
    next_state    = state;
    next_tick_cnt = tick_cnt;
    if (frame_start && moving) begin
      if (tick_cnt == LAST_TICK) begin
        next_tick_cnt = '0;
        unique case (state)
          CLOSED:  next_state = OPENING;
          OPENING: next_state = OPEN;
          OPEN:    next_state = CLOSING;
          CLOSING: next_state = CLOSED;
          default: next_state = CLOSED;
        endcase
      end else begin
        next_tick_cnt = tick_cnt + 8'd1;
      end
    end
  end

  // Both transitional states show the half-open sprite.
  always_comb begin
    next_frame_sel = 2'd0;
    unique case (next_state)
      CLOSED:  next_frame_sel = 2'd0;
      OPENING: next_frame_sel = 2'd1;
      OPEN:    next_frame_sel = 2'd2;
      CLOSING: next_frame_sel = 2'd1;
      default: next_frame_sel = 2'd0;
    endcase
  end

  // Source selection uses the registered frame_sel, so a pixel arriving in the
  // frame_start cycle is still drawn with the outgoing frame.
  always_comb begin
    sel_idx = idx_closed;
    sel_rgb = rgb_closed;
    case (frame_sel)
      2'd1: begin
        sel_idx = idx_half;
        sel_rgb = rgb_half;
      end
      2'd2: begin
        sel_idx = idx_open;
        sel_rgb = rgb_open;
      end
      default: begin
        sel_idx = idx_closed;
        sel_rgb = rgb_closed;
      end
    endcase
    opaque_next = pix_valid && (sel_idx != '0);
    rgb_next    = opaque_next ? sel_rgb : 12'h000;
  end

  // One-cycle pixel pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_opaque <= 1'b0;
      out_rgb    <= 12'h000;
    end else begin
      out_valid  <= pix_valid;
      out_opaque <= opaque_next;
      out_rgb    <= rgb_next;
    end
  end

endmodule

// File: tb/tb_pacman_mouth_anim_ctrl.sv
// Testbench for pacman_mouth_anim_ctrl: directed frame_start/moving sequences with
// hand-computed frame_sel values, plus pixel vectors whose expected outputs are
// queued at issue time and checked by an independent monitor.

module tb_pacman_mouth_anim_ctrl;

  typedef struct packed {
    logic        opaque;
    logic [11:0] rgb;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        frame_start;
  logic        moving;
  logic        pix_valid;
  logic [4:0]  idx_closed, idx_half, idx_open;
  logic [11:0] rgb_closed, rgb_half, rgb_open;
  logic [1:0]  frame_sel;
  logic        out_valid;
  logic        out_opaque;
  logic [11:0] out_rgb;

  int   compared   = 0;
  int   mismatched = 0;
  exp_t exp_q[$];

  pacman_mouth_anim_ctrl #(
    .TICKS_PER_STEP(4),
    .IDX_W(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .frame_start(frame_start),
    .moving(moving),
    .pix_valid(pix_valid),
    .idx_closed(idx_closed),
    .idx_half(idx_half),
    .idx_open(idx_open),
    .rgb_closed(rgb_closed),
    .rgb_half(rgb_half),
    .rgb_open(rgb_open),
    .frame_sel(frame_sel),
    .out_valid(out_valid),
    .out_opaque(out_opaque),
    .out_rgb(out_rgb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [11:0] actual, input logic [11:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // One stimulus cycle followed by a return to idle inputs; a valid pixel
  // queues its expected pipeline output.
  task automatic applyStimulus(input logic fs, input logic mov, input logic pv,
                               input logic exp_opaque, input logic [11:0] exp_rgb);
    exp_t e;
    @(posedge clk);
    #1;
    frame_start = fs;
    moving      = mov;
    pix_valid   = pv;
    if (pv) begin
      e.opaque = exp_opaque;
      e.rgb    = exp_rgb;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    pix_valid   = 1'b0;
  endtask

  // Monitor: consumes one expectation per valid output; idle outputs must be zero.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_valid: got out_valid 1, expected no output at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        checkOutput("pix_opaque", {11'd0, out_opaque}, {11'd0, e.opaque});
        checkOutput("pix_rgb", out_rgb, e.rgb);
      end
    end else begin
      checkOutput("idle_opaque", {11'd0, out_opaque}, 12'd0);
      checkOutput("idle_rgb", out_rgb, 12'd0);
    end
  end

  logic [1:0] step_seq [4];

  initial begin
    step_seq = '{2'd1, 2'd2, 2'd1, 2'd0};
    rst_n = 1'b0;
    frame_start = 1'b0;
    moving = 1'b0;
    pix_valid = 1'b0;
    idx_closed = 5'd9;  rgb_closed = 12'h0C0;
    idx_half   = 5'd5;  rgb_half   = 12'hBB2;
    idx_open   = 5'd0;  rgb_open   = 12'hFE1;

    // Reset state
    #12;
    checkOutput("reset_frame_sel", {10'd0, frame_sel}, 12'd0);
    checkOutput("reset_valid", {11'd0, out_valid}, 12'd0);
    checkOutput("reset_rgb", out_rgb, 12'h000);
    #1 rst_n = 1'b1;

    // Continuous animation: a step every 4 pulses
    for (int p = 1; p <= 16; p++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
      if (p == 3) checkOutput("pre_step_frame_sel", {10'd0, frame_sel}, 12'd0);
      if (p % 4 == 0) checkOutput("anim_frame_sel", {10'd0, frame_sel}, {10'd0, step_seq[p/4 - 1]});
    end

    // Freeze mid-count, then resume without losing the partial count
    for (int p = 0; p < 2; p++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
    for (int p = 0; p < 10; p++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    checkOutput("frozen_frame_sel", {10'd0, frame_sel}, 12'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
    checkOutput("resume_hold_frame_sel", {10'd0, frame_sel}, 12'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
    checkOutput("resume_step_frame_sel", {10'd0, frame_sel}, 12'd1);

    // Opaque half-open pixel
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 12'hBB2);

    // Move to open, then a transparent pixel
    for (int p = 0; p < 4; p++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
    checkOutput("open_frame_sel", {10'd0, frame_sel}, 12'd2);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 12'h000);

    // Pixel in the step-boundary frame_start cycle keeps the old frame
    for (int p = 0; p < 3; p++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
    checkOutput("boundary_pre_frame_sel", {10'd0, frame_sel}, 12'd2);
    idx_open = 5'd7; rgb_open = 12'h0A0;
    idx_half = 5'd3; rgb_half = 12'h0B0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 12'h0A0);
    checkOutput("closing_frame_sel", {10'd0, frame_sel}, 12'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 12'h0B0);

    // Reset mid-run while a valid pixel sits in the output register
    @(posedge clk);
    #1 pix_valid = 1'b1;
    exp_q.push_back('{opaque: 1'b1, rgb: 12'h0B0});
    @(posedge clk);
    #2 rst_n = 1'b0;
    pix_valid = 1'b0;
    #1;
    checkOutput("async_rst_frame_sel", {10'd0, frame_sel}, 12'd0);
    checkOutput("async_rst_valid", {11'd0, out_valid}, 12'd0);
    checkOutput("async_rst_rgb", out_rgb, 12'h000);
    #4 rst_n = 1'b1;

    // Counter restarted from zero: step lands on the 4th pulse again
    for (int p = 1; p <= 4; p++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
      if (p == 3) checkOutput("post_rst_hold_frame_sel", {10'd0, frame_sel}, 12'd0);
    end
    checkOutput("post_rst_step_frame_sel", {10'd0, frame_sel}, 12'd1);

    repeat (3) @(posedge clk);
    checkOutput("pending_outputs", 12'(exp_q.size()), 12'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
